// File: rtl/top_arith_pkg.sv
// Shared constants for the top_arith datapath q = ((a - b) * (1 + 3c) - 4d) / 2.
package top_arith_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int LATENCY            = 4;
  localparam int C_GAIN             = 3;
  localparam int D_GAIN             = 4;
  localparam int C_OFFSET           = 1;
  localparam int D_SHIFT            = $clog2(D_GAIN);

endpackage

// File: rtl/top_arith_vreg.sv
// One pipeline stage: a valid bit cleared by synchronous reset, plus a data word
// that only loads alongside a valid and is never reset.
module top_arith_vreg #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_valid <= 1'b0;
    else         r_valid <= i_valid;
  end

  // Data is gated by valid so idle cycles leave the stage untouched.
  always_ff @(posedge i_clk) begin
    if (i_valid) r_data <= i_data;
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/top_arith.sv
// Pipelined q = ((a - b) * (1 + 3c) - 4d) / 2, unsigned modulo 2^DATA_WIDTH, latency 4.
// Build option TOP_ARITH_QZERO_EN: q_o reads 0 whenever q_valid_o is low.
module top_arith
  import top_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  artsn_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic                  a_valid_i,
  input  logic                  b_valid_i,
  input  logic                  c_valid_i,
  input  logic                  d_valid_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  q_valid_o
);

  localparam int W = DATA_WIDTH;

  logic         w_accept;
  logic         w_s0Valid, w_s1Valid, w_s2Valid, w_s3Valid;
  logic [4*W-1:0] w_s0Data;
  logic [3*W-1:0] w_s1Data;
  logic [2*W-1:0] w_s2Data;
  logic [W-1:0] w_a, w_b, w_c, w_d;
  logic [W-1:0] w_diff, w_m, w_d4;
  logic [W-1:0] w_s1Diff, w_s1M, w_s1D4;
  logic [W-1:0] w_p, w_s2P, w_s2D4;
  logic [W-1:0] w_s, w_s3S;
  logic [W-1:0] r_q;
  logic         r_qValid;

  // Partial valid combinations are dropped entirely; only a full set enters.
  assign w_accept = a_valid_i & b_valid_i & c_valid_i & d_valid_i;

  top_arith_vreg #(.WIDTH(4*W)) u_capture (
    .i_clk(clk_i), .i_reset(artsn_i), .i_valid(w_accept),
    .i_data({a_i, b_i, c_i, d_i}), .o_valid(w_s0Valid), .o_data(w_s0Data)
  );

  assign {w_a, w_b, w_c, w_d} = w_s0Data;
  assign w_diff = w_a - w_b;
  assign w_m    = W'(C_OFFSET) + (w_c << 1) + w_c;
  assign w_d4   = w_d << D_SHIFT;

  top_arith_vreg #(.WIDTH(3*W)) u_stage1 (
    .i_clk(clk_i), .i_reset(artsn_i), .i_valid(w_s0Valid),
    .i_data({w_diff, w_m, w_d4}), .o_valid(w_s1Valid), .o_data(w_s1Data)
  );

  assign {w_s1Diff, w_s1M, w_s1D4} = w_s1Data;
  assign w_p = w_s1Diff * w_s1M;

  top_arith_vreg #(.WIDTH(2*W)) u_stage2 (
    .i_clk(clk_i), .i_reset(artsn_i), .i_valid(w_s1Valid),
    .i_data({w_p, w_s1D4}), .o_valid(w_s2Valid), .o_data(w_s2Data)
  );

  assign {w_s2P, w_s2D4} = w_s2Data;
  assign w_s = w_s2P - w_s2D4;

  top_arith_vreg #(.WIDTH(W)) u_stage3 (
    .i_clk(clk_i), .i_reset(artsn_i), .i_valid(w_s2Valid),
    .i_data(w_s), .o_valid(w_s3Valid), .o_data(w_s3S)
  );

  // Output stage is the only data register with a reset value.
  always_ff @(posedge clk_i) begin
    if (artsn_i) begin
      r_qValid <= 1'b0;
      r_q      <= '0;
    end else begin
      r_qValid <= w_s3Valid;
      if (w_s3Valid) r_q <= w_s3S >> 1;
`ifdef TOP_ARITH_QZERO_EN
      else           r_q <= '0;
`endif
    end
  end

  assign q_o       = r_q;
  assign q_valid_o = r_qValid;

endmodule

// File: tb/tb_top_arith.sv
// Self-checking bench for top_arith: directed literal cases plus randomized traffic
// compared every cycle against a queue-based reference of the arithmetic formula.
module tb_top_arith;

  logic        clk = 1'b0;
  logic        artsn;
  logic [31:0] a, b, c, d;
  logic        aValid, bValid, cValid, dValid;
  logic [31:0] q;
  logic        qValid;

  int checks   = 0;
  int failures = 0;

  top_arith #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .artsn_i(artsn),
    .a_i(a), .b_i(b), .c_i(c), .d_i(d),
    .a_valid_i(aValid), .b_valid_i(bValid), .c_valid_i(cValid), .d_valid_i(dValid),
    .q_o(q), .q_valid_o(qValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] val;
  } pending_t;

  pending_t    pending[$];
  int          cycle     = 0;
  logic        expValid  = 1'b0;
  logic [31:0] expQ      = '0;
  logic        checking  = 1'b0;

  function automatic logic [31:0] refQ(input logic [31:0] ra, rb, rc, rd);
    logic [31:0] diff, m, p, s;
    diff = ra - rb;
    m    = 32'd1 + 32'd3 * rc;
    p    = diff * m;
    s    = p - 32'd4 * rd;
    return s >> 1;
  endfunction

  function automatic logic [31:0] idleQ(input logic [31:0] held);
`ifdef TOP_ARITH_QZERO_EN
    return 32'd0;
`else
    return held;
`endif
  endfunction

  // Reference: every accepted set is due exactly four edges later unless a reset intervenes.
  always @(posedge clk) begin
    cycle++;
    if (artsn) begin
      pending.delete();
      expValid = 1'b0;
      expQ     = '0;
      checking = 1'b1;
    end else begin
      if (pending.size() > 0 && pending[0].due == cycle) begin
        expValid = 1'b1;
        expQ     = pending[0].val;
        void'(pending.pop_front());
      end else begin
        expValid = 1'b0;
        expQ     = idleQ(expQ);
      end
      if (aValid && bValid && cValid && dValid)
        pending.push_back('{due: cycle + 4, val: refQ(a, b, c, d)});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_valid", {31'd0, qValid}, {31'd0, expValid});
      checkOutput("model_q", q, expQ);
    end
  end

  task automatic applyStimulus(input logic [31:0] sa, sb, sc, sd,
                               input logic [3:0] valids, input logic rst);
    @(posedge clk);
    #2;
    a = sa; b = sb; c = sc; d = sd;
    {aValid, bValid, cValid, dValid} = valids;
    artsn = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0, 4'b0000, 1'b0);
  endtask

  initial begin
    artsn = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    {aValid, bValid, cValid, dValid} = 4'b0000;

    applyStimulus('0, '0, '0, '0, 4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("reset_valid", {31'd0, qValid}, 32'd0);
    checkOutput("reset_q", q, 32'd0);
    idle(1);

    $display("[TB] single set a=10 b=3 c=2 d=1");
    applyStimulus(32'd10, 32'd3, 32'd2, 32'd1, 4'b1111, 1'b0);
    idle(5);
    @(negedge clk);
    checkOutput("t1_valid", {31'd0, qValid}, 32'd1);
    checkOutput("t1_q", q, 32'd22);
    idle(1);
    @(negedge clk);
    checkOutput("t1_after_valid", {31'd0, qValid}, 32'd0);
    checkOutput("t1_hold_q", q, idleQ(32'd22));

    $display("[TB] partial valid set");
    applyStimulus(32'd7, 32'd1, 32'd1, 32'd1, 4'b1110, 1'b0);
    idle(5);
    @(negedge clk);
    checkOutput("t4_valid", {31'd0, qValid}, 32'd0);
    checkOutput("t4_q", q, idleQ(32'd22));

    $display("[TB] back-to-back sets");
    applyStimulus(32'd99, 32'd0, 32'd99, 32'd0, 4'b1111, 1'b0);
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 4'b1111, 1'b0);
    idle(4);
    @(negedge clk);
    checkOutput("t3_first_q", q, 32'd14751);
    idle(1);
    @(negedge clk);
    checkOutput("t3_second_valid", {31'd0, qValid}, 32'd1);
    checkOutput("t3_second_q", q, 32'd0);

    $display("[TB] wrap-around set");
    applyStimulus(32'd3, 32'd10, 32'd0, 32'd0, 4'b1111, 1'b0);
    idle(5);
    @(negedge clk);
    checkOutput("t2_valid", {31'd0, qValid}, 32'd1);
    checkOutput("t2_q", q, 32'h7FFF_FFFC);

    $display("[TB] reset two cycles after accept");
    applyStimulus(32'd10, 32'd3, 32'd2, 32'd1, 4'b1111, 1'b0);
    idle(2);
    artsn = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(negedge clk);
      checkOutput("t5_valid", {31'd0, qValid}, 32'd0);
      checkOutput("t5_q", q, 32'd0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] v;
      v[3] = ($urandom_range(0, 3) != 0);
      v[2] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 3) != 0);
      v[0] = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 99), $urandom_range(0, 99),
                    $urandom_range(0, 99), $urandom_range(0, 99),
                    v, ($urandom_range(0, 149) == 0));
    end
    idle(6);
    @(negedge clk);
    checkOutput("drain_empty", pending.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
